// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and helpers for the scanned 7-segment encoder:
//   mode_e      - re-encode mode selector values
//   gray4       - 4-bit binary to Gray conversion
//   hex_to_seg  - 4-bit value to active-high {g,f,e,d,c,b,a} glyph
//   SEG_OFF     - active-high glyph with every segment dark
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam int unsigned NIBBLE_W = 4;
   localparam int unsigned SEG_W    = 7;

   localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

   // Mode 3 is not named; the encoder treats it like MODE_PASS.
   typedef enum logic [1:0] {
      MODE_PASS = 2'd0,
      MODE_GRAY = 2'd1,
      MODE_LUT  = 2'd2
   } mode_e;

   function automatic logic [NIBBLE_W-1:0] gray4(input logic [NIBBLE_W-1:0] b);
      gray4 = b ^ (b >> 1);
   endfunction

   // Standard hex glyphs, bit order {g,f,e,d,c,b,a}, 1 = segment lit.
   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] v);
      hex_to_seg = SEG_OFF;
      case (v)
         4'h0: hex_to_seg = 7'h3F;
         4'h1: hex_to_seg = 7'h06;
         4'h2: hex_to_seg = 7'h5B;
         4'h3: hex_to_seg = 7'h4F;
         4'h4: hex_to_seg = 7'h66;
         4'h5: hex_to_seg = 7'h6D;
         4'h6: hex_to_seg = 7'h7D;
         4'h7: hex_to_seg = 7'h07;
         4'h8: hex_to_seg = 7'h7F;
         4'h9: hex_to_seg = 7'h6F;
         4'hA: hex_to_seg = 7'h77;
         4'hB: hex_to_seg = 7'h7C;
         4'hC: hex_to_seg = 7'h39;
         4'hD: hex_to_seg = 7'h5E;
         4'hE: hex_to_seg = 7'h79;
         4'hF: hex_to_seg = 7'h71;
         default: hex_to_seg = SEG_OFF;
      endcase
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational 4-bit to 7-segment glyph decode (active-high).
//   nibble  in  4 : value to display
//   seg_c   out 7 : {g,f,e,d,c,b,a}, 1 = lit
// -----------------------------------------------------------------------------
module seg7_decoder
   import seg7_pkg::*;
(
   input  logic [NIBBLE_W-1:0] nibble,
   output logic [SEG_W-1:0]    seg_c
);

   always_comb begin
      seg_c = hex_to_seg(nibble);
   end

endmodule

// File: rtl/seg7_scan_encoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_encoder
// Captures DIGITS 4-bit codes on `ready`, re-encodes them (pass / Gray / LUT),
// holds the result in a shadow register and commits it only on the last cycle
// of a scan frame, then time-multiplexes the committed digits onto one
// 7-segment bus with one-hot anode drive.
//
// Ports
//   clock     in  1          : rising-edge clock
//   reset     in  1          : synchronous, active-high
//   ready     in  1          : load strobe, samples data_in / mode
//   mode      in  2          : 0 pass, 1 Gray, 2 CODE_LUT, 3 as pass
//   data_in   in  4*DIGITS   : nibble i = digit i
//   blank_in  in  DIGITS     : 1 = keep digit i anode inactive (live)
//   code_out  out 4*DIGITS   : committed encoded word
//   load_ack  out 1          : one-cycle pulse per commit
//   pending   out 1          : shadow holds an uncommitted load
//   seg       out 7          : {g,f,e,d,c,b,a} of the scanned digit
//   anode     out DIGITS     : one-hot digit enable
// -----------------------------------------------------------------------------
module seg7_scan_encoder
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned SCAN_DIV       = 50000,
   parameter logic [63:0] CODE_LUT       = 64'hFEDC_BA98_7654_3210,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
)
(
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         ready,
   input  logic [1:0]                   mode,
   input  logic [NIBBLE_W*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]            blank_in,
   output logic [NIBBLE_W*DIGITS-1:0]   code_out,
   output logic                         load_ack,
   output logic                         pending,
   output logic [SEG_W-1:0]             seg,
   output logic [DIGITS-1:0]            anode
);

   localparam int unsigned DATA_W = NIBBLE_W * DIGITS;
   localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_e;

   state_e              state_q;
   logic [DATA_W-1:0]   shadow_q;
   logic [DATA_W-1:0]   code_q;
   logic                commit_q;
   logic                ack_q;
   logic                pending_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DIG_W-1:0]    dig_q;
   logic [SEG_W-1:0]    seg_q;
   logic [DIGITS-1:0]   anode_q;

   logic [DATA_W-1:0]   enc_word_c;
   logic                cnt_last_c;
   logic                dig_last_c;
   logic                frame_end_c;
   logic [NIBBLE_W-1:0] cur_nibble_c;
   logic [SEG_W-1:0]    glyph_c;
   logic [DIGITS-1:0]   anode_on_c;

   // Per-nibble re-encode of the live input word.
   always_comb begin
      enc_word_c = '0;
      for (int i = 0; i < DIGITS; i++) begin
         logic [NIBBLE_W-1:0] nib;
         nib = data_in[NIBBLE_W*i +: NIBBLE_W];
         case (mode)
            MODE_GRAY: enc_word_c[NIBBLE_W*i +: NIBBLE_W] = gray4(nib);
            MODE_LUT:  enc_word_c[NIBBLE_W*i +: NIBBLE_W] = CODE_LUT[{nib, 2'b00} +: NIBBLE_W];
            default:   enc_word_c[NIBBLE_W*i +: NIBBLE_W] = nib;
         endcase
      end
   end

   // Frame boundary: last count of the last digit.
   always_comb begin
      cnt_last_c  = (cnt_q == CNT_W'(SCAN_DIV - 1));
      dig_last_c  = (dig_q == DIG_W'(DIGITS - 1));
      frame_end_c = cnt_last_c && dig_last_c;
   end

   // Free-running scan counter and digit index.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
         dig_q <= '0;
      end else if (cnt_last_c) begin
         cnt_q <= '0;
         dig_q <= dig_last_c ? '0 : dig_q + DIG_W'(1);
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Load/commit FSM with shadow register; a ready on the frame-end cycle
   // bypasses the shadow so exactly one commit and one ack result.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shadow_q  <= '0;
         code_q    <= '0;
         commit_q  <= 1'b0;
         ack_q     <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         commit_q <= 1'b0;
         ack_q    <= commit_q;
         if (frame_end_c && (ready || (state_q == ST_PENDING))) begin
            code_q    <= ready ? enc_word_c : shadow_q;
            commit_q  <= 1'b1;
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
         end else if (ready) begin
            shadow_q  <= enc_word_c;
            state_q   <= ST_PENDING;
            pending_q <= 1'b1;
         end
      end
   end

   // Select the committed nibble for the digit being scanned.
   always_comb begin
      cur_nibble_c = '0;
      anode_on_c   = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_q == DIG_W'(i)) begin
            cur_nibble_c  = code_q[NIBBLE_W*i +: NIBBLE_W];
            anode_on_c[i] = !blank_in[i];
         end
      end
   end

   seg7_decoder u_decoder (
      .nibble (cur_nibble_c),
      .seg_c  (glyph_c)
   );

   // Segment and anode registers update together so no mixed-digit cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         seg_q   <= SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
         anode_q <= SEG_ACTIVE_LOW ? '1 : '0;
      end else begin
         seg_q   <= SEG_ACTIVE_LOW ? ~glyph_c : glyph_c;
         anode_q <= SEG_ACTIVE_LOW ? ~anode_on_c : anode_on_c;
      end
   end

   assign code_out = code_q;
   assign load_ack = ack_q;
   assign pending  = pending_q;
   assign seg      = seg_q;
   assign anode    = anode_q;

endmodule

// File: tb/tb_seg7_scan_encoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_encoder
// Directed bench: DIGITS=4, SCAN_DIV=4 (16-cycle frame), active-low drive.
// Cycle k is the interval after the k-th rising edge following the last edge
// that sampled reset high; the scan sits at count k%4, digit (k/4)%4, and
// seg/anode in cycle k show the digit scanned in cycle k-1.
// -----------------------------------------------------------------------------
module tb_seg7_scan_encoder;

   logic        clock;
   logic        reset;
   logic        ready;
   logic [1:0]  mode;
   logic [15:0] data_in;
   logic [3:0]  blank_in;
   logic [15:0] code_out;
   logic        load_ack;
   logic        pending;
   logic [6:0]  seg;
   logic [3:0]  anode;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int acks   = 0;
   int on_cnt [4];
   int multi;

   seg7_scan_encoder #(
      .DIGITS         (4),
      .SCAN_DIV       (4),
      .CODE_LUT       (64'hFEDC_BA98_7654_3210),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .ready    (ready),
      .mode     (mode),
      .data_in  (data_in),
      .blank_in (blank_in),
      .code_out (code_out),
      .load_ack (load_ack),
      .pending  (pending),
      .seg      (seg),
      .anode    (anode)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      if (load_ack === 1'b1) acks++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   initial begin
      reset    = 1'b1;
      ready    = 1'b0;
      mode     = 2'd0;
      data_in  = 16'h0;
      blank_in = 4'h0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_code",    32'(code_out), 32'h0);
      check("rst_ack",     32'(load_ack), 32'h0);
      check("rst_pending", 32'(pending),  32'h0);
      check("rst_anode",   32'(anode),    32'hF);
      check("rst_seg",     32'(seg),      32'h7F);
      reset = 1'b0;
      cyc   = 0;
      acks  = 0;

      // Pass mode at frame start: commit edge ends cycle 15.
      data_in = 16'h1234; mode = 2'd0; ready = 1'b1;
      tick(); ready = 1'b0;
      check("pass_pend1",   32'(pending),  32'h1);
      check("pass_code1",   32'(code_out), 32'h0);
      check("first_anode",  32'(anode),    32'hE);
      run_to(15);
      check("pass_code15",  32'(code_out), 32'h0);
      check("pass_pend15",  32'(pending),  32'h1);
      run_to(16);
      check("pass_code16",  32'(code_out), 32'h1234);
      check("pass_pend16",  32'(pending),  32'h0);
      check("pass_ack16",   32'(load_ack), 32'h0);
      check("pass_anode16", 32'(anode),    32'h7);
      check("pass_seg16",   32'(seg),      32'h40);
      run_to(17);
      check("pass_ack17",   32'(load_ack), 32'h1);
      check("pass_anode17", 32'(anode),    32'hE);
      check("pass_seg17",   32'(seg),      32'h19);
      run_to(21);
      check("pass_anode21", 32'(anode),    32'hD);
      check("pass_seg21",   32'(seg),      32'h30);
      check("pass_acks",    32'(acks),     32'h1);

      // Gray mode.
      run_to(32);
      data_in = 16'h000F; mode = 2'd1; ready = 1'b1;
      tick(); ready = 1'b0;
      run_to(48);
      check("gray_code",    32'(code_out), 32'h0008);
      run_to(49);
      check("gray_ack",     32'(load_ack), 32'h1);
      check("gray_seg",     32'(seg),      32'h00);

      // LUT mode with identity table.
      run_to(50);
      data_in = 16'hA5C3; mode = 2'd2; ready = 1'b1;
      tick(); ready = 1'b0;
      run_to(64);
      check("lut_code",     32'(code_out), 32'hA5C3);
      run_to(65);
      check("lut_ack",      32'(load_ack), 32'h1);

      // Overwrite within one frame.
      run_to(66);
      acks = 0;
      data_in = 16'h1111; mode = 2'd0; ready = 1'b1;
      tick(); ready = 1'b0;
      run_to(70);
      check("ovw_pend70",   32'(pending),  32'h1);
      data_in = 16'h2222; ready = 1'b1;
      tick(); ready = 1'b0;
      check("ovw_pend71",   32'(pending),  32'h1);
      run_to(79);
      check("ovw_code79",   32'(code_out), 32'hA5C3);
      run_to(80);
      check("ovw_code80",   32'(code_out), 32'h2222);
      run_to(95);
      check("ovw_acks",     32'(acks),     32'h1);

      // Ready exactly on the commit cycle while 1111 is pending.
      run_to(96);
      acks = 0;
      data_in = 16'h1111; ready = 1'b1;
      tick(); ready = 1'b0;
      run_to(111);
      check("col_pend111",  32'(pending),  32'h1);
      data_in = 16'h9999; ready = 1'b1;
      tick(); ready = 1'b0;
      check("col_code112",  32'(code_out), 32'h9999);
      check("col_pend112",  32'(pending),  32'h0);
      run_to(113);
      check("col_ack113",   32'(load_ack), 32'h1);
      run_to(140);
      check("col_pend140",  32'(pending),  32'h0);
      check("col_code140",  32'(code_out), 32'h9999);
      check("col_acks",     32'(acks),     32'h1);

      // Blank digit 1 over two frames.
      run_to(144);
      blank_in = 4'b0010;
      multi = 0;
      for (int i = 0; i < 4; i++) on_cnt[i] = 0;
      for (int k = 0; k < 32; k++) begin
         tick();
         for (int i = 0; i < 4; i++) if (anode[i] == 1'b0) on_cnt[i]++;
         if ($countones(~anode) > 1) multi++;
      end
      blank_in = 4'b0000;
      check("blank_d0",     32'(on_cnt[0]), 32'd8);
      check("blank_d1",     32'(on_cnt[1]), 32'd0);
      check("blank_d2",     32'(on_cnt[2]), 32'd8);
      check("blank_d3",     32'(on_cnt[3]), 32'd8);
      check("blank_multi",  32'(multi),     32'd0);

      // Reset while pending.
      run_to(180);
      data_in = 16'h5555; ready = 1'b1;
      tick(); ready = 1'b0;
      check("rst2_pend",    32'(pending),  32'h1);
      run_to(185);
      reset = 1'b1;
      tick();
      check("rst2_code",    32'(code_out), 32'h0);
      check("rst2_pending", 32'(pending),  32'h0);
      check("rst2_ack",     32'(load_ack), 32'h0);
      check("rst2_anode",   32'(anode),    32'hF);
      check("rst2_seg",     32'(seg),      32'h7F);
      reset = 1'b0;
      cyc   = 0;
      acks  = 0;
      tick();
      check("rst2_anode1",  32'(anode),    32'hE);
      check("rst2_seg1",    32'(seg),      32'h40);
      run_to(5);
      check("rst2_anode5",  32'(anode),    32'hD);
      run_to(40);
      check("rst2_acks",    32'(acks),     32'h0);
      check("rst2_code40",  32'(code_out), 32'h0);
      check("rst2_pend40",  32'(pending),  32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
